// File: rtl/ram_sp18_arbiter.sv
// Two-port arbiter/sequencer in front of a 1024x18 single-port block RAM.
// Grants at most one request per cycle. The granted operation is registered onto
// the RAM pins. Read data goes back to the port that issued the read.
module ram_sp18_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {PREF_A = 1'b0, PREF_B = 1'b1} pref_t;

  pref_t                 r_pref;
  pref_t                 w_pref_nxt;
  logic                  w_grant_a;
  logic                  w_grant_b;

  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_din;
  logic                  r_iss_rd;
  logic                  r_iss_own;   // 1 = port B
  logic [RD_LATENCY-1:0] r_dl_rd;
  logic [RD_LATENCY-1:0] r_dl_own;
  logic [15:0]           r_cnt;

  // Grant selection and next round-robin preference
  always_comb begin
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_pref_nxt = r_pref;
    if (a_valid && b_valid) begin
      if (ARB_MODE == 1 || r_pref == PREF_A) w_grant_a = 1'b1;
      else                                   w_grant_b = 1'b1;
    end else begin
      w_grant_a = a_valid;
      w_grant_b = b_valid;
    end
    if (w_grant_a)      w_pref_nxt = PREF_B;
    else if (w_grant_b) w_pref_nxt = PREF_A;
  end

  // Round-robin preference register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pref <= PREF_A;
    else     r_pref <= w_pref_nxt;
  end

  // Issue stage: registers the granted operation onto the RAM pins and records its read tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_iss_rd  <= 1'b0;
      r_iss_own <= 1'b0;
    end else begin
      r_we      <= (w_grant_a & a_we) | (w_grant_b & b_we);
      r_iss_rd  <= (w_grant_a & ~a_we) | (w_grant_b & ~b_we);
      r_iss_own <= w_grant_b;
      if (w_grant_a) begin
        r_addr <= a_addr;
        r_din  <= a_wdata;
      end else if (w_grant_b) begin
        r_addr <= b_addr;
        r_din  <= b_wdata;
      end
    end
  end

  // Read tag delay line, matched to the RAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dl_rd  <= '0;
      r_dl_own <= '0;
    end else begin
      r_dl_rd[0]  <= r_iss_rd;
      r_dl_own[0] <= r_iss_own;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_dl_rd[i]  <= r_dl_rd[i-1];
        r_dl_own[i] <= r_dl_own[i-1];
      end
    end
  end

  // Saturating count of cycles where both ports request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_cnt <= '0;
    else if (a_valid && b_valid && ~&r_cnt) r_cnt <= r_cnt + 16'd1;
  end

  // Ready is combinational from the grant. It is gated so reset forces it low at once.
  assign a_ready      = w_grant_a & ~rst;
  assign b_ready      = w_grant_b & ~rst;
  assign a_rvalid     = r_dl_rd[RD_LATENCY-1] & ~r_dl_own[RD_LATENCY-1];
  assign b_rvalid     = r_dl_rd[RD_LATENCY-1] &  r_dl_own[RD_LATENCY-1];
  assign a_rdata      = ram_dout;
  assign b_rdata      = ram_dout;
  assign ram_we       = r_we;
  assign ram_addr     = r_addr;
  assign ram_din      = r_din;
  assign busy         = r_we | r_iss_rd | (|r_dl_rd);
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_ram_sp18_arbiter.sv
// Bench for ram_sp18_arbiter. Instance 0 uses round-robin and instance 1 uses fixed priority.
// Each instance has its own behavioural RAM model.
module tb_ram_sp18_arbiter;

  typedef struct {
    logic [17:0] d;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        av [2];
  logic        awe [2];
  logic [9:0]  aaddr [2];
  logic [17:0] awd [2];
  logic        bv [2];
  logic        bwe [2];
  logic [9:0]  baddr [2];
  logic [17:0] bwd [2];

  logic        a_ready_s [2];
  logic        b_ready_s [2];
  logic        a_rvalid_s [2];
  logic        b_rvalid_s [2];
  logic [17:0] a_rdata_s [2];
  logic [17:0] b_rdata_s [2];
  logic        ram_we_s [2];
  logic [9:0]  ram_addr_s [2];
  logic [17:0] ram_din_s [2];
  logic [17:0] ram_dout_s [2];
  logic        busy_s [2];
  logic [15:0] cnt_s [2];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  exp_t        sbq [4][$];
  logic [17:0] sb_mem [2][1024];
  logic        pref_b [2];
  int unsigned cnt_m [2];
  int unsigned mode [2] = '{0, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [17:0] mem [0:1023];

    ram_sp18_arbiter #(.ARB_MODE(g)) u_dut (
      .clk(clk), .rst(rst),
      .a_valid(av[g]), .a_ready(a_ready_s[g]), .a_we(awe[g]), .a_addr(aaddr[g]),
      .a_wdata(awd[g]), .a_rvalid(a_rvalid_s[g]), .a_rdata(a_rdata_s[g]),
      .b_valid(bv[g]), .b_ready(b_ready_s[g]), .b_we(bwe[g]), .b_addr(baddr[g]),
      .b_wdata(bwd[g]), .b_rvalid(b_rvalid_s[g]), .b_rdata(b_rdata_s[g]),
      .ram_we(ram_we_s[g]), .ram_addr(ram_addr_s[g]), .ram_din(ram_din_s[g]),
      .ram_dout(ram_dout_s[g]), .busy(busy_s[g]), .conflict_cnt(cnt_s[g])
    );

    initial for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Single-port RAM with one cycle of read latency
    always @(posedge clk) begin
      if (ram_we_s[g]) mem[ram_addr_s[g]] <= ram_din_s[g];
      ram_dout_s[g] <= mem[ram_addr_s[g]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      av[i] = 1'b0; awe[i] = 1'b0; aaddr[i] = '0; awd[i] = '0;
      bv[i] = 1'b0; bwe[i] = 1'b0; baddr[i] = '0; bwd[i] = '0;
    end
  endtask

  task automatic set_a(input int i, input logic v, input logic we,
                       input logic [9:0] ad, input logic [17:0] wd);
    av[i] = v; awe[i] = we; aaddr[i] = ad; awd[i] = wd;
  endtask

  task automatic set_b(input int i, input logic v, input logic we,
                       input logic [9:0] ad, input logic [17:0] wd);
    bv[i] = v; bwe[i] = we; baddr[i] = ad; bwd[i] = wd;
  endtask

  // One clock. Check the readies against the model, push the expected reads,
  // cross the edge, then check the read returns.
  task automatic tick();
    logic ga, gb, rv;
    logic [17:0] rd;
    int idx;
    exp_t e;
    #1;
    for (int i = 0; i < 2; i++) begin
      ga = 1'b0; gb = 1'b0;
      if (av[i] && bv[i]) begin
        if (mode[i] == 1 || !pref_b[i]) ga = 1'b1;
        else                            gb = 1'b1;
      end else begin
        ga = av[i];
        gb = bv[i];
      end
      chk($sformatf("a_ready[%0d]", i), {31'b0, a_ready_s[i]}, {31'b0, ga});
      chk($sformatf("b_ready[%0d]", i), {31'b0, b_ready_s[i]}, {31'b0, gb});
      if (ga) begin
        if (awe[i]) sb_mem[i][aaddr[i]] = awd[i];
        else begin
          e.d = sb_mem[i][aaddr[i]]; e.due = cyc + 2;
          sbq[i*2].push_back(e);
        end
        pref_b[i] = 1'b1;
      end else if (gb) begin
        if (bwe[i]) sb_mem[i][baddr[i]] = bwd[i];
        else begin
          e.d = sb_mem[i][baddr[i]]; e.due = cyc + 2;
          sbq[i*2+1].push_back(e);
        end
        pref_b[i] = 1'b0;
      end
      if (av[i] && bv[i] && cnt_m[i] < 16'hFFFF) cnt_m[i]++;
    end
    @(posedge clk);
    cyc++;
    #2;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        idx = i*2 + p;
        rv = p ? b_rvalid_s[i] : a_rvalid_s[i];
        rd = p ? b_rdata_s[i]  : a_rdata_s[i];
        if (sbq[idx].size() > 0 && sbq[idx][0].due == cyc) begin
          e = sbq[idx].pop_front();
          chk($sformatf("rvalid[%0d.%0d]", i, p), {31'b0, rv}, 32'd1);
          chk($sformatf("rdata[%0d.%0d]", i, p), {14'b0, rd}, {14'b0, e.d});
        end else begin
          chk($sformatf("rvalid_idle[%0d.%0d]", i, p), {31'b0, rv}, 32'd0);
        end
      end
    end
  endtask

  // Assert reset with the valids held high. Every output must drop at once.
  task automatic rst_apply();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_a(i, 1'b1, 1'b0, 10'h001, 18'h1);
      set_b(i, 1'b1, 1'b0, 10'h002, 18'h2);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ram_we",   {31'b0, ram_we_s[i]}, 32'd0);
      chk("rst_ram_addr", {22'b0, ram_addr_s[i]}, 32'd0);
      chk("rst_ram_din",  {14'b0, ram_din_s[i]}, 32'd0);
      chk("rst_a_ready",  {31'b0, a_ready_s[i]}, 32'd0);
      chk("rst_b_ready",  {31'b0, b_ready_s[i]}, 32'd0);
      chk("rst_a_rvalid", {31'b0, a_rvalid_s[i]}, 32'd0);
      chk("rst_b_rvalid", {31'b0, b_rvalid_s[i]}, 32'd0);
      chk("rst_busy",     {31'b0, busy_s[i]}, 32'd0);
      chk("rst_conflict", {16'b0, cnt_s[i]}, 32'd0);
      pref_b[i] = 1'b0;
      cnt_m[i]  = 0;
    end
    for (int k = 0; k < 4; k++) sbq[k].delete();
    @(posedge clk);
    cyc++;
    #2;
    idle_all();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_all();
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 1024; k++) sb_mem[i][k] = '0;
      pref_b[i] = 1'b0;
      cnt_m[i]  = 0;
    end
    @(posedge clk);
    #2;
    rst_apply();

    // A writes 0x005 and then reads it back
    for (int i = 0; i < 2; i++) set_a(i, 1'b1, 1'b1, 10'h005, 18'h2ABCD);
    tick();
    for (int i = 0; i < 2; i++) set_a(i, 1'b1, 1'b0, 10'h005, 18'h0);
    tick();
    drain(3);

    // Preload the read targets, then start from reset so the pointer prefers A
    for (int i = 0; i < 2; i++) set_a(i, 1'b1, 1'b1, 10'h010, 18'h11111);
    tick();
    for (int i = 0; i < 2; i++) set_a(i, 1'b1, 1'b1, 10'h020, 18'h22222);
    tick();
    drain(2);
    rst_apply();

    // Both ports request for 6 cycles: instance 0 alternates, instance 1 always grants A
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin
        set_a(i, 1'b1, 1'b0, 10'h010, 18'h0);
        set_b(i, 1'b1, 1'b0, 10'h020, 18'h0);
      end
      tick();
    end
    idle_all();
    set_b(1, 1'b1, 1'b0, 10'h020, 18'h0);
    tick();
    drain(3);
    for (int i = 0; i < 2; i++) chk($sformatf("conflict6[%0d]", i), {16'b0, cnt_s[i]}, 32'd6);
    chk("busy_idle0", {31'b0, busy_s[0]}, 32'd0);

    // B writes address 1023 and A reads it on the next cycle
    for (int i = 0; i < 2; i++) set_b(i, 1'b1, 1'b1, 10'h3FF, 18'h00001);
    tick();
    idle_all();
    for (int i = 0; i < 2; i++) set_a(i, 1'b1, 1'b0, 10'h3FF, 18'h0);
    tick();
    drain(3);

    // Reset lands while a read is in flight, so the read must never return
    set_a(0, 1'b1, 1'b0, 10'h005, 18'h0);
    tick();
    idle_all();
    chk("busy_inflight", {31'b0, busy_s[0]}, 32'd1);
    rst_apply();
    drain(4);
    chk("busy_after_rst", {31'b0, busy_s[0]}, 32'd0);

    // Hold both ports valid long enough for the conflict counter to saturate
    for (int i = 0; i < 2; i++) begin
      set_a(i, 1'b1, 1'b0, 10'h000, 18'h0);
      set_b(i, 1'b1, 1'b0, 10'h000, 18'h0);
    end
    for (int k = 0; k < 65534; k++) tick();
    for (int i = 0; i < 2; i++) chk($sformatf("conflict_fffe[%0d]", i), {16'b0, cnt_s[i]}, 32'hFFFE);
    for (int k = 0; k < 4466; k++) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("conflict_sat[%0d]", i), {16'b0, cnt_s[i]}, 32'hFFFF);
      chk($sformatf("conflict_model[%0d]", i), {16'b0, cnt_s[i]}, cnt_m[i]);
    end
    drain(4);

    for (int k = 0; k < 4; k++) chk($sformatf("sb_empty[%0d]", k), sbq[k].size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
